// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared constants for the writeback / register-unit slice.
//   Contents:
//     XLEN, NREGS        default datapath width and architectural register count
//     SP_INIT_DEFAULT    reset value of the stack pointer (x2)
//     WB_SRC_*           writeback source select encodings
//     REG_ZERO, REG_SP   special register indices
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [31:0] SP_INIT_DEFAULT = 32'h0000_03FC;

    localparam logic [1:0] WB_SRC_ALU = 2'b00;
    localparam logic [1:0] WB_SRC_DM  = 2'b01;
    localparam logic [1:0] WB_SRC_PC4 = 2'b10;
    localparam logic [1:0] WB_SRC_ILL = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd2;

    typedef logic [4:0] reg_addr_t;

endpackage

// File: rtl/wb_mux.sv
// -----------------------------------------------------------------------------
// wb_mux
//   Combinational writeback source select with illegal-encoding decode.
//   Ports:
//     i_src      in   2   source select (WB_SRC_* encodings)
//     i_alu      in   W   ALU result
//     i_dm       in   W   data-memory read data
//     i_pc4      in   W   PC+4
//     o_data     out  W   selected value, zero for the illegal encoding
//     o_illegal  out  1   high when i_src is the reserved encoding
// -----------------------------------------------------------------------------
module wb_mux
    import riscv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [1:0]   i_src,
    input  logic [W-1:0] i_alu,
    input  logic [W-1:0] i_dm,
    input  logic [W-1:0] i_pc4,
    output logic [W-1:0] o_data,
    output logic         o_illegal
);

    always_comb begin
        o_data    = '0;
        o_illegal = 1'b0;
        case (i_src)
            WB_SRC_ALU: o_data = i_alu;
            WB_SRC_DM:  o_data = i_dm;
            WB_SRC_PC4: o_data = i_pc4;
            default:    o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_reg_unit.sv
// -----------------------------------------------------------------------------
// wb_reg_unit
//   Writeback stage consumer of the MEM/WB register: selects the writeback
//   value, commits it to the register array, serves two bypassed read ports,
//   and keeps a retired-write counter plus a sticky illegal-source flag.
//   Ports:
//     clk            in   1      clock, all state on posedge
//     rst            in   1      synchronous active-high reset
//     incrementPCIn  in   XLEN   PC+4
//     ALUResIn       in   XLEN   ALU result
//     DMDataRdIn     in   XLEN   data-memory read data
//     rdIn           in   5      destination register
//     ru_data_srcIn  in   2      writeback source select
//     ru_writeIn     in   1      register write enable
//     rs1, rs2       in   5      read addresses
//     ru_rs1, ru_rs2 out  XLEN   read data (combinational, bypassed)
//     wb_data        out  XLEN   selected writeback value
//     wb_count       out  CNT_W  committed write count (wraps)
//     wb_src_err     out  1      sticky illegal-source flag
// -----------------------------------------------------------------------------
module wb_reg_unit #(
    parameter int                       XLEN    = riscv_pkg::XLEN,
    parameter int                       NREGS   = riscv_pkg::NREGS,
    parameter logic [riscv_pkg::XLEN-1:0] SP_INIT = riscv_pkg::SP_INIT_DEFAULT,
    parameter int                       CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  incrementPCIn,
    input  logic [XLEN-1:0]  ALUResIn,
    input  logic [XLEN-1:0]  DMDataRdIn,
    input  logic [4:0]       rdIn,
    input  logic [1:0]       ru_data_srcIn,
    input  logic             ru_writeIn,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    output logic [XLEN-1:0]  ru_rs1,
    output logic [XLEN-1:0]  ru_rs2,
    output logic [XLEN-1:0]  wb_data,
    output logic [CNT_W-1:0] wb_count,
    output logic             wb_src_err
);

    import riscv_pkg::*;

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [CNT_W-1:0] r_count;
    logic             r_src_err;

    logic [XLEN-1:0]  w_wb_data;
    logic             w_src_ill;
    logic             w_commit;
    logic             w_bypass_en;
    logic             w_ill_req;

    wb_mux #(
        .W (XLEN)
    ) u_wb_mux (
        .i_src     (ru_data_srcIn),
        .i_alu     (ALUResIn),
        .i_dm      (DMDataRdIn),
        .i_pc4     (incrementPCIn),
        .o_data    (w_wb_data),
        .o_illegal (w_src_ill)
    );

    // ru_writeIn is the leading term so a disabled slot masks an unknown
    // source select instead of propagating it.
    assign w_commit    = ru_writeIn && (rdIn != REG_ZERO) && !w_src_ill;
    assign w_ill_req   = ru_writeIn && w_src_ill;
    assign w_bypass_en = w_commit && !rst;

    // x0 is reset to zero and never addressed by a commit, so it stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
            end
        end else if (w_commit) begin
            r_regs[rdIn] <= w_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_src_err <= 1'b0;
        end else begin
            if (w_commit) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_ill_req) begin
                r_src_err <= 1'b1;
            end
        end
    end

    // While rst is high the array may still hold pre-reset contents, so the
    // read ports report the values the array is being reset to.
    function automatic logic [XLEN-1:0] f_reset_val(input logic [4:0] addr);
        return (addr == REG_SP) ? SP_INIT : '0;
    endfunction

    always_comb begin
        ru_rs1 = r_regs[rs1];
        if (rs1 == REG_ZERO) begin
            ru_rs1 = '0;
        end else if (rst) begin
            ru_rs1 = f_reset_val(rs1);
        end else if (w_bypass_en && (rdIn == rs1)) begin
            ru_rs1 = w_wb_data;
        end
    end

    always_comb begin
        ru_rs2 = r_regs[rs2];
        if (rs2 == REG_ZERO) begin
            ru_rs2 = '0;
        end else if (rst) begin
            ru_rs2 = f_reset_val(rs2);
        end else if (w_bypass_en && (rdIn == rs2)) begin
            ru_rs2 = w_wb_data;
        end
    end

    assign wb_data    = w_wb_data;
    assign wb_count   = r_count;
    assign wb_src_err = r_src_err;

endmodule

// File: tb/tb_wb_reg_unit.sv
module tb_wb_reg_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc4, alu, dm;
    logic [4:0]  rd, rs1, rs2;
    logic [1:0]  src;
    logic        we;

    logic [31:0] a_rs1, a_rs2, a_wb, a_cnt;
    logic        a_err;
    logic [31:0] b_rs1, b_rs2, b_wb;
    logic [3:0]  b_cnt;
    logic        b_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;

    // reference model state
    logic [31:0] m_regs [32];
    int          m_commits;
    logic        m_err;

    wb_reg_unit dut (
        .clk(clk), .rst(rst),
        .incrementPCIn(pc4), .ALUResIn(alu), .DMDataRdIn(dm),
        .rdIn(rd), .ru_data_srcIn(src), .ru_writeIn(we),
        .rs1(rs1), .rs2(rs2),
        .ru_rs1(a_rs1), .ru_rs2(a_rs2), .wb_data(a_wb),
        .wb_count(a_cnt), .wb_src_err(a_err)
    );

    wb_reg_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .incrementPCIn(pc4), .ALUResIn(alu), .DMDataRdIn(dm),
        .rdIn(rd), .ru_data_srcIn(src), .ru_writeIn(we),
        .rs1(rs1), .rs2(rs2),
        .ru_rs1(b_rs1), .ru_rs2(b_rs2), .wb_data(b_wb),
        .wb_count(b_cnt), .wb_src_err(b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_wb();
        case (src)
            2'd0:    return alu;
            2'd1:    return dm;
            2'd2:    return pc4;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit exp_commit();
        return (we == 1'b1) && (rd != 5'd0) && (src != 2'd3);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (rst) return (a == 5'd2) ? 32'h3FC : 32'h0;
        if (exp_commit() && rd == a) return exp_wb();
        return m_regs[a];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = (i == 2) ? 32'h3FC : 32'h0;
            m_commits = 0;
            m_err     = 1'b0;
        end else begin
            if (exp_commit()) begin
                m_regs[rd] = exp_wb();
                m_commits++;
            end
            if (we && src == 2'd3) m_err = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("rs1",        a_rs1, exp_read(rs1));
            chk("rs2",        a_rs2, exp_read(rs2));
            chk("wb_data",    a_wb,  exp_wb());
            chk("wb_count",   a_cnt, 32'(m_commits));
            chk("src_err",    {31'b0, a_err}, {31'b0, m_err});
            chk("c4_rs1",     b_rs1, exp_read(rs1));
            chk("c4_wb_count", {28'b0, b_cnt}, 32'(m_commits % 16));
            chk("c4_src_err", {31'b0, b_err}, {31'b0, m_err});
        end
    end

    // Selected source gets v; the other two sources carry distinct junk.
    task automatic put(input logic w, input logic [1:0] s, input logic [4:0] d,
                       input logic [31:0] v, input logic [4:0] a, input logic [4:0] b);
        we  = w;
        src = s;
        rd  = d;
        alu = v ^ 32'h1111_0000;
        dm  = v ^ 32'h2222_0000;
        pc4 = v ^ 32'h4444_0000;
        case (s)
            2'd0: alu = v;
            2'd1: dm  = v;
            2'd2: pc4 = v;
            default: ;
        endcase
        rs1 = a;
        rs2 = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        put(1'b0, 2'd0, 5'd0, 32'h0, 5'd2, 5'd5);

        // reset for two edges
        tick();
        check_en = 1;
        sample();
        chk("L_rst_x2",    a_rs1, 32'h3FC);
        chk("L_rst_x5",    a_rs2, 32'h0);
        chk("L_rst_count", a_cnt, 32'h0);
        chk("L_rst_err",   {31'b0, a_err}, 32'h0);
        tick();
        rst = 1'b0;

        // writes from each source
        put(1'b1, 2'd0, 5'd5, 32'h11,  5'd0, 5'd0); tick();
        put(1'b1, 2'd1, 5'd6, 32'h22,  5'd0, 5'd0); tick();
        put(1'b1, 2'd2, 5'd7, 32'h104, 5'd0, 5'd0); tick();
        put(1'b0, 2'd0, 5'd0, 32'h0, 5'd5, 5'd6);
        sample();
        chk("L_alu_x5",  a_rs1, 32'h11);
        chk("L_dm_x6",   a_rs2, 32'h22);
        chk("L_count3",  a_cnt, 32'd3);
        tick();
        put(1'b0, 2'd0, 5'd0, 32'h0, 5'd7, 5'd2);
        sample();
        chk("L_pc4_x7",  a_rs1, 32'h104);
        tick();

        // dual-port bypass
        put(1'b1, 2'd0, 5'd9, 32'hDEAD_BEEF, 5'd9, 5'd9);
        sample();
        chk("L_byp_rs1", a_rs1, 32'hDEAD_BEEF);
        chk("L_byp_rs2", a_rs2, 32'hDEAD_BEEF);
        tick();
        put(1'b0, 2'd0, 5'd0, 32'h0, 5'd9, 5'd9);
        sample();
        chk("L_arr_x9",  a_rs1, 32'hDEAD_BEEF);
        tick();

        // one port bypassed, the other from the array
        put(1'b1, 2'd1, 5'd10, 32'h0000_CAFE, 5'd10, 5'd5); tick();

        // x0 write discarded and not counted
        put(1'b1, 2'd0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        sample();
        chk("L_x0_read", a_rs1, 32'h0);
        tick();
        put(1'b0, 2'd0, 5'd0, 32'h0, 5'd0, 5'd10);
        sample();
        chk("L_x0_count", a_cnt, 32'd5);
        tick();

        // disabled slot with illegal select is ignored
        put(1'b0, 2'd3, 5'd4, 32'h77, 5'd4, 5'd0);
        sample();
        chk("L_we0_err", {31'b0, a_err}, 32'h0);
        tick();

        // illegal source
        put(1'b1, 2'd3, 5'd4, 32'h77, 5'd4, 5'd0);
        sample();
        chk("L_ill_wb", a_wb, 32'h0);
        tick();
        put(1'b0, 2'd0, 5'd0, 32'h0, 5'd4, 5'd0);
        sample();
        chk("L_ill_x4",    a_rs1, 32'h0);
        chk("L_ill_err",   {31'b0, a_err}, 32'h1);
        chk("L_ill_count", a_cnt, 32'd5);
        tick();
        put(1'b1, 2'd3, 5'd0, 32'h78, 5'd0, 5'd0); tick();
        put(1'b1, 2'd2, 5'd12, 32'h200, 5'd12, 5'd4); tick();
        put(1'b0, 2'd0, 5'd0, 32'h0, 5'd12, 5'd0);
        sample();
        chk("L_err_sticky", {31'b0, a_err}, 32'h1);
        tick();

        // reset wins over a concurrent write
        rst = 1'b1;
        put(1'b1, 2'd0, 5'd3, 32'h55, 5'd3, 5'd2);
        sample();
        chk("L_rstw_rs1", a_rs1, 32'h0);
        chk("L_rstw_rs2", a_rs2, 32'h3FC);
        tick();

        // first post-reset edge commits normally
        rst = 1'b0;
        put(1'b1, 2'd0, 5'd3, 32'h66, 5'd3, 5'd5);
        sample();
        chk("L_post_byp",  a_rs1, 32'h66);
        chk("L_post_x5",   a_rs2, 32'h0);
        chk("L_post_cnt",  a_cnt, 32'h0);
        chk("L_post_err",  {31'b0, a_err}, 32'h0);
        tick();
        put(1'b0, 2'd0, 5'd0, 32'h0, 5'd3, 5'd12);
        sample();
        chk("L_post_x3",   a_rs1, 32'h66);
        chk("L_post_cnt1", a_cnt, 32'd1);
        tick();

        // 16 more commits: 17 total since reset, 4-bit counter wraps to 1
        for (int i = 1; i <= 16; i++) begin
            put(1'b1, 2'(i % 3), 5'(i + 10), 32'h1000 + 32'(i), 5'(i + 10), 5'd3);
            tick();
        end
        put(1'b0, 2'd0, 5'd0, 32'h0, 5'd26, 5'd11);
        sample();
        chk("L_wrap_c4",  {28'b0, b_cnt}, 32'd1);
        chk("L_cnt17",    a_cnt, 32'd17);
        chk("L_x26",      a_rs1, 32'h1010);
        tick();

        repeat (3) tick();
        check_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
